// File: rtl/data_memory_bytelane.sv
// MIPS MEM-stage data memory: byte/half/word loads and stores, registered load data,
// fault detection on range/alignment/conflict, and a post-reset clear sequencer.
module data_memory_bytelane #(
    parameter logic [31:0] BASE_ADDR      = 32'h10010000,
    parameter int          DEPTH          = 256,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [31:0] ALUresult,
    input  logic [31:0] WriteData,
    input  logic [1:0]  MemSize,
    input  logic        MemSigned,
    output logic [31:0] data_result,
    output logic        data_valid,
    output logic        mem_busy,
    output logic        mem_fault
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == AW'(DEPTH - 1)) state_d = ST_IDLE;
            end
            default: ;
        endcase
    end

    assign mem_busy = (state_q == ST_CLEAR);

    // Address decode relative to the segment base.
    logic [31:0]   off;
    logic          in_range;
    logic [AW-1:0] index;
    logic [1:0]    lane;
    logic          align_ok;
    logic          req_any, legal, do_store, do_load, fault_now;

    assign off      = ALUresult - BASE_ADDR;
    assign in_range = (ALUresult >= BASE_ADDR) && ({1'b0, off} < (33'(DEPTH) * 33'd4));
    assign index    = off[AW+1:2];
    assign lane     = off[1:0];

    always_comb begin
        align_ok = 1'b0;
        case (MemSize)
            2'b00:   align_ok = 1'b1;
            2'b01:   align_ok = ~lane[0];
            2'b10:   align_ok = (lane == 2'b00);
            default: align_ok = 1'b0;
        endcase
    end

    assign req_any   = (MemRead | MemWrite) & (state_q == ST_IDLE);
    assign legal     = in_range & align_ok & ~(MemRead & MemWrite);
    assign do_store  = req_any & MemWrite & legal;
    assign do_load   = req_any & MemRead & legal;
    assign fault_now = req_any & ~legal;

    // Lane enables and replicated store data; the clear sequencer overrides both.
    logic [3:0]    be;
    logic [31:0]   wdat;
    logic [AW-1:0] widx;

    always_comb begin
        be   = 4'b0000;
        wdat = WriteData;
        case (MemSize)
            2'b00: begin
                be   = 4'b0001 << lane;
                wdat = {4{WriteData[7:0]}};
            end
            2'b01: begin
                be   = lane[1] ? 4'b1100 : 4'b0011;
                wdat = {2{WriteData[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        if (!do_store) be = 4'b0000;
        if (state_q == ST_CLEAR) begin
            be   = 4'b1111;
            wdat = '0;
        end
        if (reset) be = 4'b0000;
    end

    assign widx = (state_q == ST_CLEAR) ? cnt_q : index;

    logic [7:0] rd_byte [4];
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] ram_q [DEPTH];
            always_ff @(posedge clk) begin
                if (be[gi]) ram_q[widx] <= wdat[8*gi +: 8];
            end
            assign rd_byte[gi] = ram_q[index];
        end
    endgenerate

    logic [31:0] rd_word;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_d;

    assign rd_word = {rd_byte[3], rd_byte[2], rd_byte[1], rd_byte[0]};

    always_comb begin
        ld_byte = rd_byte[lane];
        ld_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
        case (MemSize)
            2'b00:   load_d = {{24{MemSigned & ld_byte[7]}}, ld_byte};
            2'b01:   load_d = {{16{MemSigned & ld_half[15]}}, ld_half};
            default: load_d = rd_word;
        endcase
    end

    logic [31:0] data_result_q;
    logic        data_valid_q, mem_fault_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_result_q <= '0;
            data_valid_q  <= 1'b0;
            mem_fault_q   <= 1'b0;
        end else begin
            data_valid_q <= do_load;
            mem_fault_q  <= fault_now;
            if (do_load) data_result_q <= load_d;
        end
    end

    assign data_result = data_result_q;
    assign data_valid  = data_valid_q;
    assign mem_fault   = mem_fault_q;
endmodule

// File: tb/tb_data_memory_bytelane.sv
// Scoreboard bench for data_memory_bytelane: stimulus pushes expected responses,
// a negedge monitor pops and compares whenever the memory presents a load or fault.
module tb_data_memory_bytelane;
    localparam logic [31:0] BASE = 32'h10010000;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite, MemRead;
    logic [31:0] ALUresult, WriteData;
    logic [1:0]  MemSize;
    logic        MemSigned;
    logic [31:0] data_result;
    logic        data_valid, mem_busy, mem_fault;

    always #5 clk = ~clk;

    data_memory_bytelane #(
        .BASE_ADDR(BASE), .DEPTH(256), .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemRead(MemRead),
        .ALUresult(ALUresult), .WriteData(WriteData), .MemSize(MemSize),
        .MemSigned(MemSigned), .data_result(data_result), .data_valid(data_valid),
        .mem_busy(mem_busy), .mem_fault(mem_fault)
    );

    typedef struct {
        int          kind;   // 1 = load result, 2 = fault
        logic [31:0] data;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] last_load;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (data_valid === 1'b1 || mem_fault === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: valid=%b fault=%b data=%h, expected no response",
                         data_valid, mem_fault, data_result);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check({e.name, "_valid"}, 32'(data_valid), (e.kind == 1) ? 32'd1 : 32'd0);
                check({e.name, "_fault"}, 32'(mem_fault),  (e.kind == 2) ? 32'd1 : 32'd0);
                check({e.name, "_data"},  data_result, e.data);
                $display("txn %s: valid=%b fault=%b data=%h", e.name, data_valid, mem_fault, data_result);
            end
        end
    end

    task automatic req(input logic wr, input logic rd, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [1:0] sz, input logic sg,
                       input int kind, input logic [31:0] exp_data, input string name);
        exp_t e;
        MemWrite  = wr;
        MemRead   = rd;
        ALUresult = addr;
        WriteData = wd;
        MemSize   = sz;
        MemSigned = sg;
        if (kind == 1) last_load = exp_data;
        if (kind != 0) begin
            e.kind = kind;
            e.data = (kind == 1) ? exp_data : last_load;
            e.name = name;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        MemRead  = 1'b0;
    endtask

    task automatic lw(input logic [31:0] addr, input logic [31:0] exp_data, input string name);
        req(1'b0, 1'b1, addr, 32'h0, 2'b10, 1'b0, 1, exp_data, name);
    endtask

    task automatic sw(input logic [31:0] addr, input logic [31:0] data);
        req(1'b1, 1'b0, addr, data, 2'b10, 1'b0, 0, 32'h0, "sw");
    endtask

    // One-cycle reset, then count busy cycles. abort_at >= 0 returns early mid-clear;
    // late in a full clear, a store and a load are attempted and must be ignored.
    task automatic do_reset(input int abort_at, input string name);
        int n;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        last_load = 32'h0;
        check({name, "_result"}, data_result, 32'h0);
        check({name, "_valid"},  32'(data_valid), 32'd0);
        check({name, "_fault"},  32'(mem_fault), 32'd0);
        check({name, "_busy"},   32'(mem_busy), 32'd1);
        n = 0;
        while (mem_busy && n < 1000 && n != abort_at) begin
            MemWrite = 1'b0;
            MemRead  = 1'b0;
            if (abort_at < 0 && n == 200) begin
                MemWrite  = 1'b1;
                ALUresult = BASE;
                WriteData = 32'hDEADBEEF;
                MemSize   = 2'b10;
            end else if (abort_at < 0 && n == 201) begin
                MemRead = 1'b1;
            end
            @(posedge clk);
            #1;
            n++;
        end
        MemWrite = 1'b0;
        MemRead  = 1'b0;
        if (abort_at < 0) check({name, "_busy_cycles"}, 32'(n), 32'd256);
        $display("txn %s: busy cycles observed %0d", name, n);
    endtask

    initial begin
        reset = 1'b1; MemWrite = 1'b0; MemRead = 1'b0;
        ALUresult = '0; WriteData = '0; MemSize = 2'b10; MemSigned = 1'b0;
        last_load = '0;
        @(posedge clk);
        #1;

        do_reset(-1, "rst1");
        lw(32'h100100FC, 32'h0, "lw_top_after_clear");

        sw(BASE, 32'h8899AABB);
        req(1'b0, 1'b1, BASE + 32'd1, 32'h0, 2'b00, 1'b1, 1, 32'hFFFFFFAA, "lb_1");
        req(1'b0, 1'b1, BASE + 32'd1, 32'h0, 2'b00, 1'b0, 1, 32'h000000AA, "lbu_1");
        req(1'b0, 1'b1, BASE + 32'd2, 32'h0, 2'b01, 1'b1, 1, 32'hFFFF8899, "lh_2");
        req(1'b0, 1'b1, BASE + 32'd2, 32'h0, 2'b01, 1'b0, 1, 32'h00008899, "lhu_2");
        req(1'b0, 1'b1, BASE,         32'h0, 2'b00, 1'b1, 1, 32'hFFFFFFBB, "lb_0");
        lw(BASE, 32'h8899AABB, "lw_0");

        req(1'b1, 1'b0, BASE + 32'd6, 32'h123456C3, 2'b00, 1'b0, 0, 32'h0, "sb");
        lw(BASE + 32'd4, 32'h00C30000, "lw_after_sb");
        req(1'b1, 1'b0, BASE + 32'h12, 32'h0000BEEF, 2'b01, 1'b0, 0, 32'h0, "sh");
        lw(BASE + 32'h10, 32'hBEEF0000, "lw_after_sh");
        @(posedge clk);
        #1;

        req(1'b0, 1'b1, BASE + 32'd3,   32'h0, 2'b01, 1'b1, 2, 32'h0, "flt_lh_odd");
        req(1'b0, 1'b1, BASE + 32'd2,   32'h0, 2'b10, 1'b0, 2, 32'h0, "flt_lw_unal");
        req(1'b0, 1'b1, BASE,           32'h0, 2'b11, 1'b0, 2, 32'h0, "flt_size11");
        req(1'b0, 1'b1, 32'h10010400,   32'h0, 2'b10, 1'b0, 2, 32'h0, "flt_above");
        req(1'b0, 1'b1, 32'h1000FFFC,   32'h0, 2'b10, 1'b0, 2, 32'h0, "flt_below");
        req(1'b1, 1'b0, 32'h10010002, 32'h55555555, 2'b10, 1'b0, 2, 32'h0, "flt_sw_unal");
        lw(BASE, 32'h8899AABB, "lw_0_after_faults");
        lw(BASE + 32'd4, 32'h00C30000, "lw_4_after_faults");

        sw(BASE + 32'd8, 32'hCAFEF00D);
        req(1'b1, 1'b1, BASE + 32'd8, 32'h11111111, 2'b10, 1'b0, 2, 32'h0, "flt_rd_wr");
        lw(BASE + 32'd8, 32'hCAFEF00D, "lw_8_after_conflict");

        do_reset(100, "rst_mid");
        do_reset(-1, "rst_restart");
        lw(BASE,          32'h0, "lw_0_cleared");
        lw(BASE + 32'd4,  32'h0, "lw_4_cleared");
        lw(BASE + 32'd8,  32'h0, "lw_8_cleared");
        lw(BASE + 32'h10, 32'h0, "lw_10_cleared");
        lw(32'h100100FC,  32'h0, "lw_top_cleared");

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
